// File: rtl/uart_cpld_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_cpld_responder : rdn/wrn bus responder with 8N1 transmit and receive
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_cpld_responder #(
   parameter int CLK_DIV     = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rdn,
   input  logic       wrn,
   inout  wire  [7:0] data,
   output logic       tbre,
   output logic       tsre,
   output logic       data_ready,
   input  logic       rxd,
   output logic       txd,
   output logic       overrun,
   output logic       frame_err
);

   localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 2;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] C_HALF = CNT_W'(CLK_DIV / 2 - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] rdn_sync;
   logic [SYNC_STAGES-1:0] wrn_sync;
   logic [SYNC_STAGES-1:0] rxd_sync;
   logic                   rdn_prev;
   logic                   wrn_prev;
   logic                   rxd_prev;

   logic                   rdn_s;
   logic                   wrn_s;
   logic                   rxd_s;
   logic                   rd_rise;
   logic                   wr_rise;
   logic                   rx_fall;

   logic [7:0]             wr_latch;
   logic [7:0]             hold_reg;
   logic [7:0]             tx_shift;
   logic [2:0]             tx_bit;
   logic [CNT_W-1:0]       tx_cnt;
   state_t                 tx_state;

   logic [7:0]             rx_buf;
   logic [7:0]             rx_shift;
   logic [2:0]             rx_bit;
   logic [CNT_W-1:0]       rx_cnt;
   state_t                 rx_state;
   logic                   rx_stop_done;
   logic                   rx_stop_ok;

   // Raw rdn gates the bus so the CPU sees data within the same half-cycle.
   assign data = (!rdn) ? rx_buf : 8'hzz;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdn_sync <= '1;
         wrn_sync <= '1;
         rxd_sync <= '1;
         rdn_prev <= 1'b1;
         wrn_prev <= 1'b1;
         rxd_prev <= 1'b1;
      end else begin
         rdn_sync <= {rdn_sync[SYNC_STAGES-2:0], rdn};
         wrn_sync <= {wrn_sync[SYNC_STAGES-2:0], wrn};
         rxd_sync <= {rxd_sync[SYNC_STAGES-2:0], rxd};
         rdn_prev <= rdn_s;
         wrn_prev <= wrn_s;
         rxd_prev <= rxd_s;
      end
   end

   assign rdn_s   = rdn_sync[SYNC_STAGES-1];
   assign wrn_s   = wrn_sync[SYNC_STAGES-1];
   assign rxd_s   = rxd_sync[SYNC_STAGES-1];
   assign rd_rise = rdn_s && !rdn_prev;
   // A write overlapping a read is illegal and is ignored.
   assign wr_rise = wrn_s && !wrn_prev && rdn_s;
   assign rx_fall = !rxd_s && rxd_prev;

   // Write path and transmitter share tbre; they never touch it in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_latch <= 8'h00;
         hold_reg <= 8'h00;
         tbre     <= 1'b1;
         tsre     <= 1'b1;
         txd      <= 1'b1;
         tx_shift <= 8'h00;
         tx_bit   <= 3'd0;
         tx_cnt   <= '0;
         tx_state <= S_IDLE;
      end else begin
         if (!wrn_s && rdn_s) begin
            wr_latch <= data;
         end
         if (wr_rise && tbre) begin
            hold_reg <= wr_latch;
            tbre     <= 1'b0;
         end

         tx_cnt <= tx_cnt + 1'b1;
         case (tx_state)
            S_IDLE: begin
               tx_cnt <= '0;
               if (!tbre) begin
                  tx_shift <= hold_reg;
                  tbre     <= 1'b1;
                  tsre     <= 1'b0;
                  txd      <= 1'b0;
                  tx_state <= S_START;
               end
            end
            S_START: begin
               if (tx_cnt == C_LAST) begin
                  tx_cnt   <= '0;
                  tx_bit   <= 3'd0;
                  txd      <= tx_shift[0];
                  tx_state <= S_DATA;
               end
            end
            S_DATA: begin
               if (tx_cnt == C_LAST) begin
                  tx_cnt <= '0;
                  if (tx_bit == 3'd7) begin
                     txd      <= 1'b1;
                     tx_state <= S_STOP;
                  end else begin
                     tx_bit   <= tx_bit + 3'd1;
                     tx_shift <= {1'b0, tx_shift[7:1]};
                     txd      <= tx_shift[1];
                  end
               end
            end
            S_STOP: begin
               if (tx_cnt == C_LAST) begin
                  tx_cnt <= '0;
                  if (!tbre) begin
                     tx_shift <= hold_reg;
                     tbre     <= 1'b1;
                     txd      <= 1'b0;
                     tx_state <= S_START;
                  end else begin
                     tsre     <= 1'b1;
                     tx_state <= S_IDLE;
                  end
               end
            end
            default: begin
               tx_cnt   <= '0;
               txd      <= 1'b1;
               tx_state <= S_IDLE;
            end
         endcase
      end
   end

   assign rx_stop_done = (rx_state == S_STOP) && (rx_cnt == C_LAST);
   assign rx_stop_ok   = rx_stop_done && rxd_s;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_buf     <= 8'h00;
         rx_shift   <= 8'h00;
         rx_bit     <= 3'd0;
         rx_cnt     <= '0;
         rx_state   <= S_IDLE;
         data_ready <= 1'b0;
         overrun    <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         // A completing frame beats a simultaneous read clear.
         if (rx_stop_ok) begin
            rx_buf     <= rx_shift;
            data_ready <= 1'b1;
            if (data_ready && !rd_rise) begin
               overrun <= 1'b1;
            end
         end else if (rd_rise) begin
            data_ready <= 1'b0;
         end
         if (rx_stop_done && !rxd_s) begin
            frame_err <= 1'b1;
         end

         rx_cnt <= rx_cnt + 1'b1;
         case (rx_state)
            S_IDLE: begin
               rx_cnt <= '0;
               if (rx_fall) begin
                  rx_state <= S_START;
               end
            end
            S_START: begin
               if (rx_cnt == C_HALF) begin
                  rx_cnt   <= '0;
                  rx_bit   <= 3'd0;
                  rx_state <= rxd_s ? S_IDLE : S_DATA;
               end
            end
            S_DATA: begin
               if (rx_cnt == C_LAST) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rxd_s, rx_shift[7:1]};
                  rx_bit   <= rx_bit + 3'd1;
                  if (rx_bit == 3'd7) begin
                     rx_state <= S_STOP;
                  end
               end
            end
            S_STOP: begin
               if (rx_cnt == C_LAST) begin
                  rx_cnt   <= '0;
                  rx_state <= S_IDLE;
               end
            end
            default: begin
               rx_cnt   <= '0;
               rx_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_cpld_responder.sv
`default_nettype none
// tb_uart_cpld_responder : randomized self-checking bench against a frame-level model
module tb_uart_cpld_responder;

   localparam int CLK_DIV = 16;
   localparam int SYNC    = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rdn = 1'b1;
   logic       wrn = 1'b1;
   logic       rxd = 1'b1;
   logic [7:0] drv = 8'h00;
   logic       drv_en = 1'b0;
   wire  [7:0] data;
   logic       tbre, tsre, data_ready, txd, overrun, frame_err;

   assign data = drv_en ? drv : 8'hzz;

   uart_cpld_responder #(.CLK_DIV(CLK_DIV), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst(rst), .rdn(rdn), .wrn(wrn), .data(data),
      .tbre(tbre), .tsre(tsre), .data_ready(data_ready), .rxd(rxd),
      .txd(txd), .overrun(overrun), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // receive-side model
   logic [7:0] m_buf = 8'h00;
   logic       m_ready = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;

   // frames observed on txd
   logic [7:0] tx_q[$];
   int         tx_t[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i == 9) return 1'b1;
      return b[i-1];
   endfunction

   task automatic bus_write(input logic [7:0] b);
      drv    = b;
      drv_en = 1'b1;
      wrn    = 1'b0;
      tick(4);
      wrn    = 1'b1;
   endtask

   task automatic probe_released(input string tag);
      drv    = 8'h00;
      drv_en = 1'b1;
      #1;
      check(tag, data, 8'h00);
      drv_en = 1'b0;
   endtask

   task automatic bus_read();
      drv_en = 1'b0;
      rdn    = 1'b0;
      #1;
      check("rd_data", data, m_buf);
      tick(3);
      rdn = 1'b1;
      tick(SYNC + 2);
      m_ready = 1'b0;
      check("rd_clear", data_ready, m_ready);
      probe_released("rd_release");
   endtask

   task automatic tx_check(input logic [7:0] b);
      bus_write(b);
      tick(SYNC + 1);
      check("tbre_fall", tbre, 1'b0);
      tick(1);
      check("tbre_rise", tbre, 1'b1);
      check("tsre_busy", tsre, 1'b0);
      tick(CLK_DIV / 2);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("txd_bit%0d", i), txd, frame_bit(b, i));
         if (i < 9) tick(CLK_DIV);
      end
      tick(CLK_DIV / 2 - 1);
      check("tsre_stop", tsre, 1'b0);
      tick(1);
      check("tsre_idle", tsre, 1'b1);
      drv_en = 1'b0;
   endtask

   task automatic rx_frame(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      tick(CLK_DIV);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         tick(CLK_DIV);
      end
      rxd = stop;
      tick(CLK_DIV / 2);
      check("rx_ready_pre", data_ready, m_ready);
      if (stop) begin
         if (m_ready) m_ovr = 1'b1;
         m_buf   = b;
         m_ready = 1'b1;
      end else begin
         m_ferr = 1'b1;
      end
      tick(CLK_DIV / 4);
      check("rx_ready_post", data_ready, m_ready);
      check("rx_overrun", overrun, m_ovr);
      check("rx_frame_err", frame_err, m_ferr);
      tick(CLK_DIV / 4);
      rxd = 1'b1;
      tick(4);
   endtask

   initial begin : tx_monitor
      logic [7:0] mb;
      int         st;
      forever begin
         @(posedge clk);
         #2;
         if (rst && txd === 1'b0) begin
            st = cyc;
            repeat (CLK_DIV / 2) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CLK_DIV) @(posedge clk);
               #2;
               mb[i] = txd;
            end
            repeat (CLK_DIV) @(posedge clk);
            tx_q.push_back(mb);
            tx_t.push_back(st);
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin : stimulus
      logic [7:0] b1, b2, b3;
      tick(3);
      check("rst_txd", txd, 1'b1);
      check("rst_tbre", tbre, 1'b1);
      check("rst_tsre", tsre, 1'b1);
      check("rst_ready", data_ready, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      check("rst_frame_err", frame_err, 1'b0);
      probe_released("rst_release");
      rst = 1'b1;
      tick(5);
      check("post_rst_txd", txd, 1'b1);
      check("post_rst_tbre", tbre, 1'b1);

      // single frames, exact timing
      tx_check(8'hA5);
      tick(5);
      tx_check(8'($urandom));
      tick(5);
      tx_check(8'($urandom));
      tick(20);

      // back-to-back frames, third write dropped while holding register full
      tx_q.delete();
      tx_t.delete();
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      b3 = 8'($urandom);
      bus_write(b1);
      tick(40);
      bus_write(b2);
      tick(10);
      check("b2b_tbre_full", tbre, 1'b0);
      bus_write(b3);
      tick(5);
      drv_en = 1'b0;
      tick(400);
      check("b2b_count", tx_q.size(), 2);
      if (tx_q.size() >= 2) begin
         check("b2b_byte0", tx_q[0], b1);
         check("b2b_byte1", tx_q[1], b2);
         check("b2b_gap", tx_t[1] - tx_t[0], 10 * CLK_DIV);
      end
      check("b2b_tsre", tsre, 1'b1);
      check("b2b_tbre", tbre, 1'b1);

      // receive, read, overrun, framing error, glitch
      rx_frame(8'h5A, 1'b1);
      bus_read();
      rx_frame(8'h11, 1'b1);
      rx_frame(8'h22, 1'b1);
      bus_read();
      rx_frame(8'h77, 1'b0);
      bus_read();
      rxd = 1'b0;
      tick(4);
      rxd = 1'b1;
      tick(3 * CLK_DIV);
      check("glitch_ready", data_ready, m_ready);
      check("glitch_ferr", frame_err, m_ferr);
      check("glitch_ovr", overrun, m_ovr);

      // reset in the middle of a transmit frame
      bus_write(8'($urandom));
      tick(50);
      rst = 1'b0;
      #1;
      check("midrst_txd", txd, 1'b1);
      check("midrst_tsre", tsre, 1'b1);
      check("midrst_tbre", tbre, 1'b1);
      check("midrst_ovr", overrun, 1'b0);
      check("midrst_ferr", frame_err, 1'b0);
      m_buf = 8'h00; m_ready = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
      drv_en = 1'b0;
      tick(3);
      rst = 1'b1;
      tick(5);

      // randomized receive traffic
      for (int k = 0; k < 8; k++) begin
         rx_frame(8'($urandom), ($urandom_range(0, 3) != 0));
         if ($urandom_range(0, 1) == 1) bus_read();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
